// File: rtl/trace_capture_if.sv
// -----------------------------------------------------------------------------
// trace_capture_if
// Bundles the capture, control, readout and status signals of
// trace_capture_buffer so the buffer and its driver share one connection.
//
// Signals (names match the buffer's documented ports):
//   arm        master->slave  one-cycle pulse: clear buffer, start capturing
//   trig_pc    master->slave  trigger PC
//   cap_valid  master->slave  a commit record is presented this cycle
//   cap_pc     master->slave  record PC
//   cap_instr  master->slave  record instruction word
//   cap_result master->slave  record ALU result
//   rd_idx     master->slave  readout index, 0 = oldest retained record
//   rd_pc      slave->master  PC of the record read out (1-cycle latency)
//   rd_instr   slave->master  instruction of the record read out
//   rd_result  slave->master  ALU result of the record read out
//   count      slave->master  number of valid entries, 0..DEPTH
//   state      slave->master  0 IDLE, 1 PRE, 2 POST, 3 DONE
//   triggered  slave->master  trigger record has been captured
//   done       slave->master  capture window frozen
// -----------------------------------------------------------------------------
interface trace_capture_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            arm;
  logic [XLEN-1:0] trig_pc;
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_instr;
  logic [XLEN-1:0] cap_result;
  logic [AW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [XLEN-1:0] rd_result;
  logic [AW:0]     count;
  logic [1:0]      state;
  logic            triggered;
  logic            done;

  modport master (
    output arm, trig_pc, cap_valid, cap_pc, cap_instr, cap_result, rd_idx,
    input  rd_pc, rd_instr, rd_result, count, state, triggered, done
  );

  modport slave (
    input  arm, trig_pc, cap_valid, cap_pc, cap_instr, cap_result, rd_idx,
    output rd_pc, rd_instr, rd_result, count, state, triggered, done
  );
endinterface

// File: rtl/trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer
// Records per-instruction commit records {PC, instruction, ALU result} into a
// circular buffer. After arm it captures continuously; when a record's PC
// matches trig_pc it captures POST_TRIG further records and then freezes, so
// the buffer holds a window around the trigger for post-mortem readout.
// Readout is indexed oldest-first and registered (1-cycle latency).
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  trace_capture_if.slave (capture inputs, readout, status)
//
// Parameters:
//   XLEN      width of PC and result fields
//   DEPTH     buffer entries, power of two, >= 4
//   POST_TRIG records captured after the trigger record, 0..DEPTH-1
// -----------------------------------------------------------------------------
module trace_capture_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input logic           clk,
  input logic           rst,
  trace_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] result;
  } rec_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_post_cnt;
  logic          r_triggered;
  logic          r_done;
  rec_t          r_mem [DEPTH];
  rec_t          r_rd;

  state_t        w_state_next;
  logic          w_hit;
  logic          w_clear;
  logic          w_wr_en;
  logic          w_load_post;
  logic          w_dec_post;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_in_range;
  rec_t          w_wr_rec;

  assign w_hit    = bus.cap_valid && (bus.cap_pc == bus.trig_pc);
  assign w_wr_rec = '{pc: bus.cap_pc, instr: bus.cap_instr, result: bus.cap_result};

  // Next-state and control decode. arm overrides everything, including a
  // record presented in the same cycle.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_wr_en      = 1'b0;
    w_load_post  = 1'b0;
    w_dec_post   = 1'b0;
    if (bus.arm) begin
      w_clear      = 1'b1;
      w_state_next = S_PRE;
    end else begin
      case (r_state)
        S_PRE: begin
          if (bus.cap_valid) begin
            w_wr_en = 1'b1;
            if (w_hit) begin
              w_load_post  = 1'b1;
              w_state_next = (POST_TRIG == 0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          // Further hits are just ordinary records here.
          if (bus.cap_valid) begin
            w_wr_en    = 1'b1;
            w_dec_post = 1'b1;
            if (r_post_cnt == AW'(1)) w_state_next = S_DONE;
          end
        end
        default: ; // IDLE ignores captures; DONE is frozen
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == S_DONE);
      if (w_clear) begin
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_triggered <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          if (r_count != DEPTH_CNT) r_count <= r_count + (AW+1)'(1);
        end
        if (w_load_post) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= POST_INIT;
        end else if (w_dec_post) begin
          r_post_cnt <= r_post_cnt - AW'(1);
        end
      end
    end
  end

  // NOTE: the storage array has no reset; count alone decides which entries
  // are valid, so clearing it would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_rec;
  end

  // Oldest retained entry sits count slots behind the write pointer. When the
  // buffer is full count[AW-1:0] is zero, so the oldest is at wr_ptr itself.
  assign w_rd_addr     = r_wr_ptr - r_count[AW-1:0] + bus.rd_idx;
  assign w_rd_in_range = ({1'b0, bus.rd_idx} < r_count);

  // Reads see the array as of the previous edge; no forwarding of a write
  // landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                r_rd <= '0;
    else if (w_rd_in_range) r_rd <= r_mem[w_rd_addr];
    else                    r_rd <= '0;
  end

  assign bus.rd_pc     = r_rd.pc;
  assign bus.rd_instr  = r_rd.instr;
  assign bus.rd_result = r_rd.result;
  assign bus.count     = r_count;
  assign bus.state     = r_state;
  assign bus.triggered = r_triggered;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_capture_buffer
// Two buffers (DEPTH=8; POST_TRIG=3 and POST_TRIG=0) driven by the same
// stimulus. A reference model keeps the retained records as an oldest-first
// list and is compared against both buffers every cycle; scenario tasks add
// hand-derived expectations for the interesting points.
// -----------------------------------------------------------------------------
module tb_trace_capture_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [31:0]   trig_pc = '0;
  logic          cap_valid = 1'b0;
  logic [31:0]   cap_pc = '0;
  logic [31:0]   cap_instr = '0;
  logic [31:0]   cap_result = '0;
  logic [AW-1:0] rd_idx = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trace_capture_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if_a ();
  trace_capture_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if_b ();

  assign if_a.arm = arm;        assign if_b.arm = arm;
  assign if_a.trig_pc = trig_pc;   assign if_b.trig_pc = trig_pc;
  assign if_a.cap_valid = cap_valid; assign if_b.cap_valid = cap_valid;
  assign if_a.cap_pc = cap_pc;     assign if_b.cap_pc = cap_pc;
  assign if_a.cap_instr = cap_instr; assign if_b.cap_instr = cap_instr;
  assign if_a.cap_result = cap_result; assign if_b.cap_result = cap_result;
  assign if_a.rd_idx = rd_idx;     assign if_b.rd_idx = rd_idx;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(3)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // ---------------- reference model (index 0 -> dut_a, 1 -> dut_b) ---------
  rec_t m_list  [2][DEPTH];   // retained records, oldest first
  int   m_cnt   [2] = '{0, 0};
  int   m_state [2] = '{0, 0}; // 0 IDLE 1 PRE 2 POST 3 DONE
  bit   m_trig  [2] = '{0, 0};
  bit   m_done  [2] = '{0, 0};
  int   m_post  [2] = '{0, 0};
  rec_t m_rd    [2] = '{'0, '0};

  function automatic void model_push(int k, rec_t r);
    if (m_cnt[k] == DEPTH) begin
      for (int i = 0; i < DEPTH - 1; i++) m_list[k][i] = m_list[k][i+1];
      m_list[k][DEPTH-1] = r;
    end else begin
      m_list[k][m_cnt[k]] = r;
      m_cnt[k]++;
    end
  endfunction

  function automatic void model_update(int k);
    int   pt = (k == 0) ? 3 : 0;
    rec_t r;
    if (rst) begin
      m_state[k] = 0; m_cnt[k] = 0; m_trig[k] = 0; m_done[k] = 0;
      m_post[k] = 0; m_rd[k] = '0;
      return;
    end
    m_rd[k] = (int'(rd_idx) < m_cnt[k]) ? m_list[k][rd_idx] : '0;
    if (arm) begin
      m_cnt[k] = 0; m_trig[k] = 0; m_done[k] = 0; m_state[k] = 1;
    end else if (cap_valid && (m_state[k] == 1 || m_state[k] == 2)) begin
      r = '{pc: cap_pc, instr: cap_instr, result: cap_result};
      model_push(k, r);
      if (m_state[k] == 1) begin
        if (cap_pc == trig_pc) begin
          m_trig[k] = 1;
          if (pt == 0) begin
            m_state[k] = 3; m_done[k] = 1;
          end else begin
            m_state[k] = 2; m_post[k] = pt;
          end
        end
      end else begin
        m_post[k]--;
        if (m_post[k] == 0) begin
          m_state[k] = 3; m_done[k] = 1;
        end
      end
    end
  endfunction

  // Advance one clock, update the model, and compare both buffers #1 later.
  task automatic cycle();
    logic [103:0] obs, exp;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    obs = {if_a.state, if_a.count, if_a.triggered, if_a.done,
           if_a.rd_pc, if_a.rd_instr, if_a.rd_result};
    exp = {2'(m_state[0]), 4'(m_cnt[0]), m_trig[0], m_done[0], m_rd[0]};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL model_a t=%0t got=%h exp=%h", $time, obs, exp);
    end
    obs = {if_b.state, if_b.count, if_b.triggered, if_b.done,
           if_b.rd_pc, if_b.rd_instr, if_b.rd_result};
    exp = {2'(m_state[1]), 4'(m_cnt[1]), m_trig[1], m_done[1], m_rd[1]};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL model_b t=%0t got=%h exp=%h", $time, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] pc);
    cap_valid  = 1'b1;
    cap_pc     = pc;
    cap_instr  = $urandom;
    cap_result = pc + 32'd1;
    cycle();
    cap_valid  = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] tpc);
    trig_pc = tpc;
    arm     = 1'b1;
    cycle();
    arm     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({if_a.state, if_a.count, if_a.done, if_a.triggered} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_status got=%h exp=00",
               {if_a.state, if_a.count, if_a.done, if_a.triggered});
    end
    n_checks++;
    if ({if_a.rd_pc, if_a.rd_instr, if_a.rd_result} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_rd got=%h exp=0", {if_a.rd_pc, if_a.rd_instr, if_a.rd_result});
    end
  endtask

  task automatic test_unarmed();
    for (int i = 0; i < 8; i++) feed(32'(i * 4));
    n_checks++;
    if (if_a.count !== 4'd0 || if_a.state !== 2'd0) begin
      n_fail++;
      $display("FAIL unarmed count=%0d state=%0d exp count=0 state=0", if_a.count, if_a.state);
    end
  endtask

  task automatic test_wrap_window();
    do_arm(32'h14);
    for (int i = 0; i < 9; i++) begin
      feed(32'(i * 4));
      if (i == 7) begin
        n_checks++;
        if (if_a.done !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_early_done got=%b exp=0", if_a.done);
        end
      end
    end
    n_checks++;
    if (if_a.done !== 1'b1 || if_a.count !== 4'd8 || if_a.state !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_done done=%b count=%0d state=%0d exp 1/8/3",
               if_a.done, if_a.count, if_a.state);
    end
    feed(32'h24);
    n_checks++;
    if (if_a.count !== 4'd8) begin
      n_fail++;
      $display("FAIL wrap_extra_count got=%0d exp=8", if_a.count);
    end
    rd_idx = 3'd0; cycle();
    n_checks++;
    if (if_a.rd_pc !== 32'h04) begin
      n_fail++;
      $display("FAIL wrap_rd0 got=%h exp=00000004", if_a.rd_pc);
    end
    rd_idx = 3'd4; cycle();
    n_checks++;
    if (if_a.rd_pc !== 32'h14 || if_a.rd_result !== 32'h15) begin
      n_fail++;
      $display("FAIL wrap_rd4 pc=%h result=%h exp 14/15", if_a.rd_pc, if_a.rd_result);
    end
    rd_idx = 3'd7; cycle();
    n_checks++;
    if (if_a.rd_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL wrap_rd7 got=%h exp=00000020", if_a.rd_pc);
    end
    rd_idx = 3'd0;
  endtask

  task automatic test_early_gaps();
    do_arm(32'h00);
    feed(32'h00); cycle();
    feed(32'h04); cycle();
    feed(32'h08); cycle();
    n_checks++;
    if (if_a.done !== 1'b0 || if_a.state !== 2'd2) begin
      n_fail++;
      $display("FAIL gaps_before done=%b state=%0d exp 0/2", if_a.done, if_a.state);
    end
    feed(32'h0C);
    n_checks++;
    if (if_a.done !== 1'b1 || if_a.count !== 4'd4) begin
      n_fail++;
      $display("FAIL gaps_done done=%b count=%0d exp 1/4", if_a.done, if_a.count);
    end
    rd_idx = 3'd4; cycle();
    n_checks++;
    if ({if_a.rd_pc, if_a.rd_instr, if_a.rd_result} !== 96'h0) begin
      n_fail++;
      $display("FAIL gaps_rd4 got=%h exp=0", {if_a.rd_pc, if_a.rd_instr, if_a.rd_result});
    end
    rd_idx = 3'd0;
  endtask

  task automatic test_post_trig_zero();
    do_arm(32'h08);
    feed(32'h00);
    feed(32'h04);
    feed(32'h08);
    n_checks++;
    if (if_b.state !== 2'd3 || if_b.done !== 1'b1 || if_b.count !== 4'd3) begin
      n_fail++;
      $display("FAIL pt0_done state=%0d done=%b count=%0d exp 3/1/3",
               if_b.state, if_b.done, if_b.count);
    end
    feed(32'h08);
    n_checks++;
    if (if_b.count !== 4'd3) begin
      n_fail++;
      $display("FAIL pt0_frozen count=%0d exp=3", if_b.count);
    end
  endtask

  task automatic test_reset_rearm();
    // dut_b is in DONE here
    do_arm(32'h10);
    n_checks++;
    if (if_b.state !== 2'd1 || if_b.count !== 4'd0 || if_b.triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_from_done state=%0d count=%0d trig=%b exp 1/0/0",
               if_b.state, if_b.count, if_b.triggered);
    end
    feed(32'h00);
    // arm coincident with a record: record dropped
    arm = 1'b1;
    feed(32'h40);
    arm = 1'b0;
    n_checks++;
    if (if_a.count !== 4'd0 || if_b.count !== 4'd0) begin
      n_fail++;
      $display("FAIL arm_with_valid count_a=%0d count_b=%0d exp 0/0", if_a.count, if_b.count);
    end
    feed(32'h0C);
    feed(32'h10);
    feed(32'h14);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (if_a.state !== 2'd0 || if_a.count !== 4'd0 || if_a.triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_post state=%0d count=%0d trig=%b exp 0/0/0",
               if_a.state, if_a.count, if_a.triggered);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      arm        = ($urandom_range(0, 15) == 0);
      if (arm) trig_pc = 32'($urandom_range(0, 15) * 4);
      cap_valid  = ($urandom_range(0, 9) < 6);
      cap_pc     = 32'($urandom_range(0, 15) * 4);
      cap_instr  = $urandom;
      cap_result = $urandom;
      rd_idx     = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    rst = 1'b0; arm = 1'b0; cap_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unarmed();
    test_wrap_window();
    test_early_gaps();
    test_post_trig_zero();
    test_reset_rearm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
